mem_bus_arb: RTL

- Two-host to one-memory-port arbiter for the SoC memory bus (req/we/addr/data/mask out; gnt/valid/data/error back).
- Lets two bus hosts (e.g. core data port and a debug/DMA host) share one RAM or ROM port.
- Arbitrates requests round-robin and forwards the winner downstream.
- Tracks outstanding transactions in an in-order tag FIFO and routes each response to the host that issued it.

---
 rtl/mem_bus_arb.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_arb.sv
// Two-host arbiter onto one memory port, round-robin (host 0 fixed priority when MEM_ARB_FIXED_PRIO_EN); in-order tag FIFO routes responses.
// Zero added grant latency (follows m_gnt combinationally); requests stall while DEPTH transactions are outstanding.
module mem_bus_arb #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      h0_req,
  input  logic                      h0_we,
  input  logic [AW-1:0]             h0_addr,
  input  logic [DW-1:0]             h0_wdata,
  input  logic [DW/8-1:0]           h0_mask,
  output logic                      h0_gnt,
  output logic                      h0_rvalid,
  output logic [DW-1:0]             h0_rdata,
  output logic [1:0]                h0_err,
  input  logic                      h1_req,
  input  logic                      h1_we,
  input  logic [AW-1:0]             h1_addr,
  input  logic [DW-1:0]             h1_wdata,
  input  logic [DW/8-1:0]           h1_mask,
  output logic                      h1_gnt,
  output logic                      h1_rvalid,
  output logic [DW-1:0]             h1_rdata,
  output logic [1:0]                h1_err,
  output logic                      m_req,
  output logic                      m_we,
  output logic [AW-1:0]             m_addr,
  output logic [DW-1:0]             m_wdata,
  output logic [DW/8-1:0]           m_mask,
  input  logic                      m_gnt,
  input  logic                      m_rvalid,
  input  logic [DW-1:0]             m_rdata,
  input  logic [1:0]                m_err,
  output logic [$clog2(DEPTH):0]    outstanding,
  output logic                      spurious
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] tag_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             spurious_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic             last_q;
`endif

  logic full, empty;
  logic sel_vld, sel_host;
  logic push, pop, head;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  always_comb begin
    sel_vld  = 1'b0;
    sel_host = 1'b0;
    if (!full) begin
      if (h0_req && h1_req) begin
        sel_vld = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        sel_host = 1'b0;
`else
        sel_host = ~last_q;
`endif
      end else if (h0_req) begin
        sel_vld  = 1'b1;
        sel_host = 1'b0;
      end else if (h1_req) begin
        sel_vld  = 1'b1;
        sel_host = 1'b1;
      end
    end
  end

  always_comb begin
    m_req   = sel_vld;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_mask  = '0;
    if (sel_vld) begin
      m_we    = sel_host ? h1_we    : h0_we;
      m_addr  = sel_host ? h1_addr  : h0_addr;
      m_wdata = sel_host ? h1_wdata : h0_wdata;
      m_mask  = sel_host ? h1_mask  : h0_mask;
    end
  end

  assign push   = sel_vld & m_gnt;
  assign h0_gnt = push & ~sel_host;
  assign h1_gnt = push & sel_host;

  // The head tag is registered, so a response can never be routed in its own grant cycle.
  assign pop  = m_rvalid & ~empty;
  assign head = tag_q[rd_ptr_q];

  assign h0_rvalid = pop & ~head;
  assign h1_rvalid = pop & head;
  assign h0_rdata  = h0_rvalid ? m_rdata : '0;
  assign h0_err    = h0_rvalid ? m_err   : 2'b00;
  assign h1_rdata  = h1_rvalid ? m_rdata : '0;
  assign h1_err    = h1_rvalid ? m_err   : 2'b00;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign outstanding = cnt_q;
  assign spurious    = spurious_q;

  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[wr_ptr_q] <= sel_host;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      spurious_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (m_rvalid && empty) begin
        spurious_q <= 1'b1;
      end
    end
  end

`ifndef MEM_ARB_FIXED_PRIO_EN
  // Reset to host 1 so host 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (push) begin
      last_q <= sel_host;
    end
  end
`endif

endmodule
